// File: rtl/led_chase_pkg.sv
// Shared types and constants for the two-dot LED chase checker.
// Optional bidirectional tracking is enabled by defining LED_CHASE_BIDIR_EN.
package led_chase_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCK   = 2'd2
  } chase_state_e;

  localparam logic [1:0] FLT_NONE  = 2'd0;
  localparam logic [1:0] FLT_SHAPE = 2'd1;
  localparam logic [1:0] FLT_STEP  = 2'd2;
  localparam logic [1:0] FLT_STALL = 2'd3;

endpackage

// File: rtl/led_pattern_decode.sv
// Combinational decoder: recognises rotl(2'b11, k) on the LED bus and reports k.
module led_pattern_decode
  import led_chase_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]         led,
  output logic                     shape_ok,
  output logic [$clog2(WIDTH)-1:0] k
);

  localparam int K_W = $clog2(WIDTH);

  logic [WIDTH-1:0] hit;

  // One exact-match comparator per rotation; the last one is the MSB/LSB wrap.
  genvar gi;
  for (gi = 0; gi < WIDTH; gi++) begin : g_pat
    localparam logic [WIDTH-1:0] PAT = (WIDTH'(1) << gi) | (WIDTH'(1) << ((gi + 1) % WIDTH));
    assign hit[gi] = (led == PAT);
  end

  always_comb begin
    shape_ok = |hit;
    k        = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (hit[i]) k = K_W'(i);
    end
  end

endmodule

// File: rtl/led_chase_checker.sv
// Monitors the two-dot chaser bus: locks onto the rotation, counts good steps, flags faults.
// Define LED_CHASE_BIDIR_EN to accept a chaser running in either direction.
module led_chase_checker
  import led_chase_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int MAX_HOLD = 50_000_000,
  parameter int CNT_W    = 16
) (
  input  logic                     clki,
  input  logic                     rs,
  input  logic [WIDTH-1:0]         led,
  input  logic                     clr,
  output logic                     locked,
  output logic                     err,
  output logic [1:0]               fault_code,
  output logic [$clog2(WIDTH)-1:0] position,
  output logic [CNT_W-1:0]         step_count,
  output logic [CNT_W-1:0]         err_count
);

  localparam int K_W    = $clog2(WIDTH);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  chase_state_e      state_q, state_d;
  logic [WIDTH-1:0]  led_q, ref_q, ref_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [K_W-1:0]    pos_q, pos_d;
  logic              err_q, err_d;
  logic [1:0]        fault_q, fault_d;
  logic [CNT_W-1:0]  step_q, step_d, errc_q, errc_d;

  logic              shape_ok;
  logic [K_W-1:0]    dec_k;
  logic              change, step_left, good_step;
  logic              step_hit, fault_hit;
  logic [1:0]        fault_sel;

  led_pattern_decode #(.WIDTH(WIDTH)) u_decode (
    .led      (led_q),
    .shape_ok (shape_ok),
    .k        (dec_k)
  );

  assign change    = (led_q != ref_q);
  assign step_left = change && (led_q == {ref_q[WIDTH-2:0], ref_q[WIDTH-1]});
  assign hold_d    = change ? '0 : ((hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_W'(1));

`ifdef LED_CHASE_BIDIR_EN
  logic dir_q, dir_d;  // 1: chaser runs MSB towards LSB
  logic step_right;
  assign step_right = change && (led_q == {ref_q[0], ref_q[WIDTH-1:1]});
  assign good_step  = (state_q == ALIGN) ? (step_left || step_right)
                                         : (dir_q ? step_right : step_left);
`else
  assign good_step  = step_left;
`endif

  always_ff @(posedge clki or posedge rs) begin
    if (rs) state_q <= SEARCH;
    else    state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ref_d     = ref_q;
    pos_d     = pos_q;
    step_hit  = 1'b0;
    fault_hit = 1'b0;
    fault_sel = FLT_NONE;
`ifdef LED_CHASE_BIDIR_EN
    dir_d     = dir_q;
`endif
    unique case (state_q)
      SEARCH: begin
`ifdef LED_CHASE_BIDIR_EN
        dir_d = 1'b0;
`endif
        if (shape_ok) begin
          ref_d   = led_q;
          pos_d   = dec_k;
          state_d = ALIGN;
        end
      end
      ALIGN: begin
        if (good_step) begin
          ref_d    = led_q;
          pos_d    = dec_k;
          step_hit = 1'b1;
          state_d  = LOCK;
`ifdef LED_CHASE_BIDIR_EN
          dir_d    = !step_left;
`endif
        end else if (change && shape_ok) begin
          ref_d = led_q;
          pos_d = dec_k;
        end else if (change || (hold_q == HOLD_MAX)) begin
          state_d = SEARCH;
        end
      end
      LOCK: begin
        if (good_step) begin
          ref_d    = led_q;
          pos_d    = dec_k;
          step_hit = 1'b1;
        end else if (change && !shape_ok) begin
          fault_hit = 1'b1;
          fault_sel = FLT_SHAPE;
        end else if (change) begin
          fault_hit = 1'b1;
          fault_sel = FLT_STEP;
        end else if (hold_q == HOLD_MAX) begin
          fault_hit = 1'b1;
          fault_sel = FLT_STALL;
        end
      end
      default: state_d = SEARCH;
    endcase
    if (fault_hit) state_d = SEARCH;

    // clr beats a simultaneous fault for the counters and code, but not for the err pulse.
    err_d = fault_hit;
    if (clr) begin
      step_d  = '0;
      errc_d  = '0;
      fault_d = FLT_NONE;
    end else begin
      step_d  = (step_hit && (step_q != CNT_MAX)) ? step_q + CNT_W'(1) : step_q;
      errc_d  = (fault_hit && (errc_q != CNT_MAX)) ? errc_q + CNT_W'(1) : errc_q;
      fault_d = fault_hit ? fault_sel : fault_q;
    end
  end

  always_ff @(posedge clki or posedge rs) begin
    if (rs) begin
      led_q   <= '0;
      ref_q   <= '0;
      hold_q  <= '0;
      pos_q   <= '0;
      err_q   <= 1'b0;
      fault_q <= FLT_NONE;
      step_q  <= '0;
      errc_q  <= '0;
    end else begin
      led_q   <= led;
      ref_q   <= ref_d;
      hold_q  <= hold_d;
      pos_q   <= pos_d;
      err_q   <= err_d;
      fault_q <= fault_d;
      step_q  <= step_d;
      errc_q  <= errc_d;
    end
  end

`ifdef LED_CHASE_BIDIR_EN
  always_ff @(posedge clki or posedge rs) begin
    if (rs) dir_q <= 1'b0;
    else    dir_q <= dir_d;
  end
`endif

  always_comb begin
    locked     = (state_q == LOCK);
    err        = err_q;
    fault_code = fault_q;
    position   = pos_q;
    step_count = step_q;
    err_count  = errc_q;
  end

endmodule

// File: tb/tb_led_chase_checker.sv
// Directed bench for led_chase_checker (WIDTH=8, MAX_HOLD=20, CNT_W=4).
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
module tb_led_chase_checker;

  logic       clki = 1'b0;
  logic       rs   = 1'b1;
  logic [7:0] led  = 8'h00;
  logic       clr  = 1'b0;
  logic       locked, err;
  logic [1:0] fault_code;
  logic [2:0] position;
  logic [3:0] step_count, err_count;

  int total_cnt  = 0;
  int pass_cnt   = 0;
  int err_pulses = 0;

  led_chase_checker #(.WIDTH(8), .MAX_HOLD(20), .CNT_W(4)) dut (
    .clki       (clki),
    .rs         (rs),
    .led        (led),
    .clr        (clr),
    .locked     (locked),
    .err        (err),
    .fault_code (fault_code),
    .position   (position),
    .step_count (step_count),
    .err_count  (err_count)
  );

  always #5 clki = ~clki;

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] led;
    logic       locked;
    logic [2:0] pos;
    logic [3:0] steps;
  } vec_t;

  vec_t vec [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clki);
    #1;
  endtask

  task automatic cyc_watch(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1);
      if (err) err_pulses++;
    end
  endtask

  task automatic apply(input logic [7:0] v, input int n);
    led = v;
    cyc(n);
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  initial begin
    vec[0] = '{8'h03, 1'b0, 3'd0, 4'd0};
    vec[1] = '{8'h06, 1'b1, 3'd1, 4'd1};
    vec[2] = '{8'h0C, 1'b1, 3'd2, 4'd2};
    vec[3] = '{8'h18, 1'b1, 3'd3, 4'd3};
    vec[4] = '{8'h30, 1'b1, 3'd4, 4'd4};
    vec[5] = '{8'h60, 1'b1, 3'd5, 4'd5};
    vec[6] = '{8'hC0, 1'b1, 3'd6, 4'd6};
    vec[7] = '{8'h81, 1'b1, 3'd7, 4'd7};
    vec[8] = '{8'h03, 1'b1, 3'd0, 4'd8};

    #100;
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_fault", 32'(fault_code), 32'd0);
    chk("rst_pos", 32'(position), 32'd0);
    chk("rst_steps", 32'(step_count), 32'd0);
    chk("rst_errcnt", 32'(err_count), 32'd0);
    cyc(1);
    rs = 1'b0;
    cyc(1);

`ifdef LED_CHASE_BIDIR_EN
    // Reverse-running chaser from the start must lock without errors.
    foreach (vec[i]) begin
      led = rotl8(8'h03, (8 - i) % 8);
      cyc_watch(10);
    end
    chk("rev_locked", 32'(locked), 32'd1);
    chk("rev_steps", 32'(step_count), 32'd8);
    chk("rev_no_err", 32'(err_pulses), 32'd0);
    rs = 1'b1;
    cyc(2);
    rs = 1'b0;
    led = 8'h00;
    cyc(2);
`else
    // Reverse-running chaser never locks when only left rotation counts.
    foreach (vec[i]) begin
      led = rotl8(8'h03, (8 - i) % 8);
      cyc_watch(10);
    end
    chk("rev_unlocked", 32'(locked), 32'd0);
    chk("rev_steps", 32'(step_count), 32'd0);
    chk("rev_no_err", 32'(err_pulses), 32'd0);
    rs = 1'b1;
    cyc(2);
    rs = 1'b0;
    led = 8'h00;
    cyc(2);
`endif

    for (int i = 0; i < 9; i++) begin
      led = vec[i].led;
      for (int c = 0; c < 10; c++) begin
        cyc(1);
        if (err) err_pulses++;
        if (c == 1) begin
          $display("vec %0d led=%02h locked=%0b pos=%0d steps=%0d", i, vec[i].led, locked, position, step_count);
          chk($sformatf("chase_locked[%0d]", i), 32'(locked), 32'(vec[i].locked));
          chk($sformatf("chase_pos[%0d]", i), 32'(position), 32'(vec[i].pos));
          chk($sformatf("chase_steps[%0d]", i), 32'(step_count), 32'(vec[i].steps));
        end
      end
    end
    chk("chase_no_err", 32'(err_pulses), 32'd0);

    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("clr_steps", 32'(step_count), 32'd0);
    chk("clr_keeps_lock", 32'(locked), 32'd1);
    chk("clr_keeps_pos", 32'(position), 32'd0);

    apply(8'h06, 10);
    apply(8'h0C, 10);
    apply(8'h0E, 2);
    $display("shape fault: err=%0b code=%0d errcnt=%0d locked=%0b", err, fault_code, err_count, locked);
    chk("shape_err", 32'(err), 32'd1);
    chk("shape_code", 32'(fault_code), 32'd1);
    chk("shape_errcnt", 32'(err_count), 32'd1);
    chk("shape_unlock", 32'(locked), 32'd0);
    cyc(1);
    chk("shape_err_1cyc", 32'(err), 32'd0);
    cyc(7);

    apply(8'h0C, 10);
    apply(8'h18, 2);
    chk("relock", 32'(locked), 32'd1);
    cyc(8);
    apply(8'h0C, 2);
    $display("step fault: err=%0b code=%0d errcnt=%0d", err, fault_code, err_count);
    chk("step_err", 32'(err), 32'd1);
    chk("step_code", 32'(fault_code), 32'd2);
    chk("step_errcnt", 32'(err_count), 32'd2);
    cyc(8);

    apply(8'h18, 10);
    apply(8'h30, 2);
    chk("stall_pre_locked", 32'(locked), 32'd1);
    chk("stall_pos", 32'(position), 32'd4);
    cyc(20);
    chk("stall_not_yet", 32'(err), 32'd0);
    chk("stall_still_locked", 32'(locked), 32'd1);
    cyc(1);
    $display("stall fault: err=%0b code=%0d errcnt=%0d", err, fault_code, err_count);
    chk("stall_err", 32'(err), 32'd1);
    chk("stall_code", 32'(fault_code), 32'd3);
    chk("stall_errcnt", 32'(err_count), 32'd3);
    chk("stall_unlock", 32'(locked), 32'd0);

    // clr sampled on the same edge that detects a fault.
    apply(8'h00, 3);
    apply(8'h0C, 10);
    apply(8'h18, 10);
    led = 8'h0E;
    cyc(1);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    $display("clr+fault: err=%0b code=%0d errcnt=%0d pos=%0d", err, fault_code, err_count, position);
    chk("clrf_err", 32'(err), 32'd1);
    chk("clrf_errcnt", 32'(err_count), 32'd0);
    chk("clrf_code", 32'(fault_code), 32'd0);
    chk("clrf_unlock", 32'(locked), 32'd0);
    chk("clrf_pos", 32'(position), 32'd3);
    cyc(1);
    chk("clrf_err_1cyc", 32'(err), 32'd0);

    for (int i = 0; i < 18; i++) apply(rotl8(8'h03, (2 + i) % 8), 4);
    $display("saturation: steps=%0d locked=%0b pos=%0d", step_count, locked, position);
    chk("sat_steps", 32'(step_count), 32'd15);
    chk("sat_locked", 32'(locked), 32'd1);
    chk("sat_pos", 32'(position), 32'd3);
    chk("sat_errcnt", 32'(err_count), 32'd0);

    @(posedge clki);
    #3;
    rs = 1'b1;
    #1;
    $display("async reset: locked=%0b steps=%0d pos=%0d", locked, step_count, position);
    chk("arst_locked", 32'(locked), 32'd0);
    chk("arst_steps", 32'(step_count), 32'd0);
    chk("arst_pos", 32'(position), 32'd0);
    cyc(2);
    rs = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
